calc_exec: RTL and testbench

Execution stage directly downstream of the two-cycle packet holder. Consumes the assembled 70-bit command word {tag, cmd, op1, op2}, queues it in a small FIFO, executes add, subtract, shift-left or shift-right, and emits one registered response per command with tag, response code and 32-bit result. Shifts are iterative (one bit per cycle) unless the fast-shift option is compiled in.

---
 rtl/calc_pkg.sv | 64 ++++++
 rtl/calc_cmd_fifo.sv | 59 +++++
 rtl/calc_exec.sv | 155 +++++++++++++++
 tb/tb_calc_exec.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, response codes, command struct and arithmetic helper for calc_exec
package calc_pkg;

   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   typedef struct packed {
      logic [1:0]  tag;
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
   } calc_cmd_t;

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } calc_result_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SHIFT
   } calc_state_t;

   // Shifts report success with op1 unchanged; the caller supplies the shifted value.
   function automatic calc_result_t calc_arith(input logic [3:0] cmd,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      calc_result_t r;
      logic [32:0]  sum;
      r.resp = RESP_ERR;
      r.data = '0;
      sum    = {1'b0, a} + {1'b0, b};
      case (cmd)
         CMD_ADD: begin
            if (!sum[32]) begin
               r.resp = RESP_OK;
               r.data = sum[31:0];
            end
         end
         CMD_SUB: begin
            if (b <= a) begin
               r.resp = RESP_OK;
               r.data = a - b;
            end
         end
         CMD_SHL, CMD_SHR: begin
            r.resp = RESP_OK;
            r.data = a;
         end
         default: begin
            r.resp = RESP_ERR;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - synchronous command FIFO with full/empty flags and occupancy count
module calc_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 70,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/calc_exec.sv
// rtl/calc_exec.sv - queued add/sub/shift execution stage; CALC_EXEC_FAST_SHIFT_EN selects barrel shifts
module calc_exec
   import calc_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [69:0] pkt_in,
   output logic        out_valid,
   output logic [1:0]  out_tag,
   output logic [1:0]  out_resp,
   output logic [31:0] out_data,
   output logic        fifo_full,
   output logic        drop_err
);

   calc_cmd_t    pkt;
   calc_cmd_t    head;
   calc_cmd_t    work;
   calc_state_t  state;
   calc_result_t arith;

   logic             push;
   logic             pop;
   logic             drop;
   logic             fifo_full_w;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             is_shift;
   logic             finish;
   logic [4:0]       shamt;
   logic [1:0]       res_resp;
   logic [31:0]      res_data;

   assign pkt       = pkt_in;
   assign push      = (pkt.cmd != 4'd0) && (!fifo_full_w || pop);
   assign drop      = (pkt.cmd != 4'd0) && fifo_full_w && !pop;
   assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign is_shift  = (work.cmd == CMD_SHL) || (work.cmd == CMD_SHR);
   assign shamt     = work.op2[4:0];
   assign pop       = !fifo_empty && ((state == ST_IDLE) || finish);

   calc_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (70),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (pkt),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full_w),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

`ifdef CALC_EXEC_FAST_SHIFT_EN
   assign finish = (state == ST_EXEC);
`else
   logic        iterate;
   logic [4:0]  sh_cnt;
   logic [31:0] sh_val;
   logic [31:0] sh_next;

   assign iterate = is_shift && (shamt != 5'd0);
   assign sh_next = (work.cmd == CMD_SHL) ? {sh_val[30:0], 1'b0} : {1'b0, sh_val[31:1]};
   assign finish  = ((state == ST_EXEC) && !iterate) || ((state == ST_SHIFT) && (sh_cnt == 5'd1));
`endif

   always_comb begin
      arith    = calc_arith(work.cmd, work.op1, work.op2);
      res_resp = arith.resp;
      res_data = arith.data;
`ifdef CALC_EXEC_FAST_SHIFT_EN
      if (is_shift) begin
         res_data = (work.cmd == CMD_SHL) ? (work.op1 << shamt) : (work.op1 >> shamt);
      end
`else
      // The last shift step is folded into the response so no extra cycle is spent.
      if (state == ST_SHIFT) begin
         res_data = sh_next;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         work      <= '0;
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_resp  <= RESP_NONE;
         out_data  <= '0;
         drop_err  <= 1'b0;
`ifndef CALC_EXEC_FAST_SHIFT_EN
         sh_cnt    <= '0;
         sh_val    <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_resp  <= RESP_NONE;
         out_data  <= '0;
         if (drop) begin
            drop_err <= 1'b1;
         end
         if (pop) begin
            work <= head;
         end
         if (finish) begin
            out_valid <= 1'b1;
            out_tag   <= work.tag;
            out_resp  <= res_resp;
            out_data  <= res_data;
         end
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state <= ST_EXEC;
               end
            end
`ifdef CALC_EXEC_FAST_SHIFT_EN
            ST_EXEC: begin
               state <= fifo_empty ? ST_IDLE : ST_EXEC;
            end
`else
            ST_EXEC: begin
               if (iterate) begin
                  sh_cnt <= shamt;
                  sh_val <= work.op1;
                  state  <= ST_SHIFT;
               end else begin
                  state  <= fifo_empty ? ST_IDLE : ST_EXEC;
               end
            end
            ST_SHIFT: begin
               sh_val <= sh_next;
               sh_cnt <= sh_cnt - 5'd1;
               if (sh_cnt == 5'd1) begin
                  state <= fifo_empty ? ST_IDLE : ST_EXEC;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_exec.sv
// tb/tb_calc_exec.sv - scoreboard bench for calc_exec
module tb_calc_exec;

`ifdef CALC_EXEC_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [69:0] pkt_in;
   logic        out_valid;
   logic [1:0]  out_tag;
   logic [1:0]  out_resp;
   logic [31:0] out_data;
   logic        fifo_full;
   logic        drop_err;

   typedef struct {
      logic [1:0]  tag;
      logic [1:0]  resp;
      logic [31:0] data;
      int          issue;
      int          lat;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   calc_exec #(.FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .pkt_in    (pkt_in),
      .out_valid (out_valid),
      .out_tag   (out_tag),
      .out_resp  (out_resp),
      .out_data  (out_data),
      .fifo_full (fifo_full),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 output logic [1:0] r, output logic [31:0] d);
      logic [32:0] s;
      r = 2'b10;
      d = 32'h0;
      case (cmd)
         4'd1: begin
            s = {1'b0, a} + {1'b0, b};
            if (s[32] == 1'b0) begin r = 2'b01; d = s[31:0]; end
         end
         4'd2: if (a >= b) begin r = 2'b01; d = a - b; end
         4'd5: begin r = 2'b01; d = a << b[4:0]; end
         4'd6: begin r = 2'b01; d = a >> b[4:0]; end
         default: ;
      endcase
   endfunction

   // Response monitor: pops the scoreboard on every out_valid, checks idle zeros otherwise.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (out_valid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_resp: got tag=%0d resp=%0d data=%h with empty scoreboard", out_tag, out_resp, out_data);
            end else begin
               mon_e = q.pop_front();
               if ({out_tag, out_resp, out_data} !== {mon_e.tag, mon_e.resp, mon_e.data}) begin
                  bad++;
                  $display("FAIL resp_fields: got tag=%0d resp=%0d data=%h expected tag=%0d resp=%0d data=%h",
                           out_tag, out_resp, out_data, mon_e.tag, mon_e.resp, mon_e.data);
               end
               if (mon_e.lat >= 0) begin
                  total++;
                  if ((cyc - mon_e.issue) != mon_e.lat) begin
                     bad++;
                     $display("FAIL resp_latency: got %0d cycles expected %0d", cyc - mon_e.issue, mon_e.lat);
                  end
               end
            end
         end else begin
            total++;
            if ({out_resp, out_data} !== 34'h0) begin
               bad++;
               $display("FAIL idle_outputs: got resp=%0d data=%h expected 0 0", out_resp, out_data);
            end
         end
      end
   end

   task automatic send(input logic [1:0] tag, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input bit accept, input bit chk_lat);
      exp_t e;
      @(negedge clk);
      pkt_in = {tag, cmd, a, b};
      if (accept) begin
         e.tag = tag;
         model(cmd, a, b, e.resp, e.data);
         e.issue = cyc + 1;
         e.lat   = -1;
         if (chk_lat) begin
            e.lat = 2;
            if (!FAST && (cmd == 4'd5 || cmd == 4'd6)) e.lat = 2 + int'(b[4:0]);
         end
         q.push_back(e);
      end
   endtask

   task automatic idle_bus();
      @(negedge clk);
      pkt_in = '0;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (q.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d responses outstanding expected 0", q.size());
         q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      pkt_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_tag, out_resp, out_data} !== 37'h0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%0b tag=%0d resp=%0d data=%h expected all 0",
                  out_valid, out_tag, out_resp, out_data);
      end
      total++;
      if ({fifo_full, drop_err} !== 2'b00) begin
         bad++;
         $display("FAIL reset_flags: got full=%0b drop=%0b expected 0 0", fifo_full, drop_err);
      end
      reset = 1'b0;
   endtask

   task automatic test_add_latency();
      send(2'd1, 4'd1, 32'd5, 32'd7, 1'b1, 1'b1);
      idle_bus();
      drain(20);
   endtask

   task automatic test_errors();
      send(2'd2, 4'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1); idle_bus(); drain(20);
      send(2'd3, 4'd2, 32'd3, 32'd4, 1'b1, 1'b1);         idle_bus(); drain(20);
      send(2'd0, 4'd3, 32'd9, 32'd9, 1'b1, 1'b1);         idle_bus(); drain(20);
      send(2'd1, 4'd2, 32'd50, 32'd50, 1'b1, 1'b1);       idle_bus(); drain(20);
      send(2'd2, 4'd1, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b1); idle_bus(); drain(20);
   endtask

   task automatic test_shift();
      send(2'd1, 4'd5, 32'd1, 32'h24, 1'b1, 1'b1);        idle_bus(); drain(60);
      send(2'd2, 4'd6, 32'hF0, 32'd4, 1'b1, 1'b1);        idle_bus(); drain(60);
      send(2'd3, 4'd5, 32'hABCD, 32'h20, 1'b1, 1'b1);     idle_bus(); drain(60);
      send(2'd0, 4'd6, 32'hDEAD_BEEF, 32'h1F, 1'b1, 1'b1); idle_bus(); drain(60);
   endtask

   task automatic test_full_drop();
      for (int i = 0; i < 4; i++) begin
         send(2'(i), 4'd6, 32'h8000_0000, 32'd31, 1'b1, (i == 0));
      end
      send(2'd0, 4'd1, 32'd0, 32'd1, 1'b1, 1'b0);
      send(2'd1, 4'd1, 32'd0, 32'd1, FAST, 1'b0);
      @(posedge clk);
      #1;
      total++;
      if (fifo_full !== !FAST) begin
         bad++;
         $display("FAIL full_flag: got %0b expected %0b", fifo_full, !FAST);
      end
      total++;
      if (drop_err !== !FAST) begin
         bad++;
         $display("FAIL drop_err_set: got %0b expected %0b", drop_err, !FAST);
      end
      idle_bus();
      drain(400);
      total++;
      if ({fifo_full, drop_err} !== {1'b0, !FAST}) begin
         bad++;
         $display("FAIL drop_err_sticky: got full=%0b drop=%0b expected 0 %0b", fifo_full, drop_err, !FAST);
      end
   endtask

   task automatic test_back_to_back();
      send(2'd0, 4'd1, 32'd1, 32'd2, 1'b1, 1'b1);
      send(2'd1, 4'd1, 32'd100, 32'd200, 1'b1, 1'b1);
      send(2'd2, 4'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
      send(2'd3, 4'd2, 32'd7, 32'd2, 1'b1, 1'b1);
      idle_bus();
      drain(30);
   endtask

   task automatic test_reset_mid_shift();
      send(2'd2, 4'd5, 32'd3, 32'd20, 1'b1, 1'b0);
      send(2'd3, 4'd1, 32'd4, 32'd4, 1'b1, 1'b0);
      idle_bus();
      repeat (5) @(negedge clk);
      if (FAST) q.delete();
      reset = 1'b1;
      q.delete();
      @(negedge clk);
      total++;
      if ({out_valid, out_tag, out_resp, out_data, fifo_full, drop_err} !== 39'h0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got valid=%0b resp=%0d data=%h full=%0b drop=%0b expected all 0",
                  out_valid, out_resp, out_data, fifo_full, drop_err);
      end
      reset = 1'b0;
      repeat (40) @(negedge clk);
      send(2'd1, 4'd1, 32'd20, 32'd22, 1'b1, 1'b1);
      idle_bus();
      drain(20);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add_latency();
      test_errors();
      test_shift();
      test_full_drop();
      test_back_to_back();
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
